store_req_unit: RTL and testbench

- Store-side counterpart of the writeback control unit's load extraction path.
- Accepts store instructions from the execute stage and builds byte-enable masks and lane-shifted write data.
- Issues registered valid/ready requests to the data memory/MMIO port; stalls the core while a request is outstanding.
- Splits misaligned stores that cross a word boundary into two word beats.

---
 rtl/store_req_unit_pkg.sv | 18 +
 rtl/store_req_unit_lane_align.sv | 39 +++
 rtl/store_req_unit.sv | 161 ++++++++++++++++
 tb/tb_store_req_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_req_unit_pkg.sv
// Shared store opcode/funct3 constants and the store-decode helper
// used by the store request path.
package store_req_unit_pkg;

  localparam logic [4:0] OPC_STORE_5 = 5'b01000;
  localparam logic [2:0] FNC_SB      = 3'b000;
  localparam logic [2:0] FNC_SH      = 3'b001;
  localparam logic [2:0] FNC_SW      = 3'b010;

  function automatic logic is_store(
    input logic [4:0] opc,
    input logic [2:0] f3
  );
    return (opc == OPC_STORE_5) &&
           (f3 == FNC_SB || f3 == FNC_SH || f3 == FNC_SW);
  endfunction

endpackage

// File: rtl/store_req_unit_lane_align.sv
// store_lane_align: builds the 8-lane byte mask and 64-bit lane-shifted
// data for a store at byte offset off_i; purely combinational.
module store_lane_align
  import store_req_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rs2_i,
  output logic [7:0]  m8_o,
  output logic [63:0] d64_o
);

  logic [7:0]  base;
  logic [31:0] data;

  always_comb begin
    base = 8'h00;
    data = rs2_i;
    unique case (1'b1)
      (funct3_i == FNC_SB): begin
        base = 8'h01;
        data = {4{rs2_i[7:0]}};
      end
      (funct3_i == FNC_SH): begin
        base = 8'h03;
        data = {2{rs2_i[15:0]}};
      end
      (funct3_i == FNC_SW): begin
        base = 8'h0f;
        data = rs2_i;
      end
      default: ;
    endcase
  end

  assign m8_o  = base << off_i;
  assign d64_o = {32'b0, data} << {off_i, 3'b000};

endmodule

// File: rtl/store_req_unit.sv
// store_req_unit: execute-stage stores -> word-aligned valid/ready beats.
// STORE_SPLIT_EN defined: word-crossing stores issue a second beat.
module store_req_unit
  import store_req_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              in_ready,
  output logic              stall,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_we,
  output logic              misalign_err
);

`ifdef STORE_SPLIT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        we_q, we_d;
  logic [7:0]        m8;
  logic [63:0]       d64;
  logic [ADDR_W-1:0] base_addr;
  logic              is_st, hs, last, accept;

  logic unused_instr_bits;
  assign unused_instr_bits =
    ^{instruction[31:15], instruction[11:7], instruction[1:0]};

  store_lane_align u_align (
    .funct3_i (instruction[14:12]),
    .off_i    (addr[1:0]),
    .rs2_i    (rs2_data),
    .m8_o     (m8),
    .d64_o    (d64)
  );

  assign base_addr = {addr[ADDR_W-1:2], 2'b00};
  assign is_st     = is_store(instruction[6:2], instruction[14:12]);
  assign hs        = (state_q != IDLE) & mem_ready;

`ifdef STORE_SPLIT_EN
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [DATA_W-1:0] wdata1_q, wdata1_d;
  logic [3:0]        we1_q, we1_d;
  logic              pend_q, pend_d;

  // pend_q is only ever set while in SEND0
  assign last         = hs & ((state_q == SEND1) | ~pend_q);
  assign misalign_err = 1'b0;
`else
  logic err_q, err_d;
  logic [31:0] unused_hi;

  assign unused_hi    = d64[63:32];
  assign last         = hs;
  assign misalign_err = err_q;
`endif

  assign in_ready  = (state_q == IDLE) | last;
  assign accept    = in_valid & is_st & in_ready;
  assign stall     = in_valid & is_st & ~in_ready;
  assign mem_valid = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
`ifdef STORE_SPLIT_EN
    addr1_d  = addr1_q;
    wdata1_d = wdata1_q;
    we1_d    = we1_q;
    pend_d   = pend_q;
`else
    err_d    = 1'b0;
`endif
    if (hs) begin
      state_d = IDLE;
      we_d    = 4'b0000;
    end
`ifdef STORE_SPLIT_EN
    if (hs && pend_q) begin
      state_d = SEND1;
      addr_d  = addr1_q;
      wdata_d = wdata1_q;
      we_d    = we1_q;
      pend_d  = 1'b0;
    end
`endif
    if (accept) begin
      state_d = SEND0;
      addr_d  = base_addr;
      wdata_d = d64[31:0];
      we_d    = m8[3:0];
`ifdef STORE_SPLIT_EN
      addr1_d  = base_addr + ADDR_W'(4);
      wdata1_d = d64[63:32];
      we1_d    = m8[7:4];
      pend_d   = |m8[7:4];
`else
      err_d    = |m8[7:4];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= '0;
`ifdef STORE_SPLIT_EN
      addr1_q  <= '0;
      wdata1_q <= '0;
      we1_q    <= '0;
      pend_q   <= 1'b0;
`else
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
`ifdef STORE_SPLIT_EN
      addr1_q  <= addr1_d;
      wdata1_q <= wdata1_d;
      we1_q    <= we1_d;
      pend_q   <= pend_d;
`else
      err_q    <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_store_req_unit.sv
// Self-checking bench for store_req_unit: directed table, corner
// sequences and a randomized run against a byte-level reference model.
module tb_store_req_unit;

  localparam logic [4:0] OPC_ST = 5'b01000;
`ifdef STORE_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, mem_ready;
  logic [31:0] instruction, addr, rs2_data;
  logic        in_ready, stall, mem_valid, misalign_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_we;

  store_req_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .instruction  (instruction),
    .addr         (addr),
    .rs2_data     (rs2_data),
    .in_ready     (in_ready),
    .stall        (stall),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] rs2;
    logic [31:0] a0;
    logic [3:0]  we0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  we1;
    logic [31:0] d1;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] d;
  } beat_t;

  vec_t        tbl[7];
  beat_t       q[$];
  beat_t       b;
  logic        eerr, st, exp_ir;
  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [31:0] tmp;
  logic [7:0]  rm;
  logic [63:0] rd;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] o,
                                     input logic [2:0] f);
    return {17'd0, f, 5'd0, o, 2'b11};
  endfunction

  // byte j of the 64-bit lane window holds data byte (j-off)
  function automatic void ref_lanes(input logic [2:0] fn,
                                    input logic [1:0] off,
                                    input logic [31:0] rs2,
                                    output logic [7:0] m,
                                    output logic [63:0] d);
    int sz;
    sz = (fn == 3'd0) ? 1 : (fn == 3'd1) ? 2 : 4;
    m = '0;
    d = '0;
    for (int j = 0; j < 8; j++) begin
      int k;
      k = j - int'(off);
      if (k >= 0 && k < 4) d[8*j +: 8] = rs2[8*(k % sz) +: 8];
      if (k >= 0 && k < sz) m[j] = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   nb;
    logic ee;
    nb = (SPLIT && v.we1 != 4'b0) ? 2 : 1;
    ee = !SPLIT && v.we1 != 4'b0;
    in_valid    = 1'b1;
    instruction = mk(OPC_ST, v.f3);
    addr        = v.a;
    rs2_data    = v.rs2;
    mem_ready   = 1'b1;
    #4;
    chk("vec_in_ready", in_ready, 1'b1);
    chk("vec_stall", stall, 1'b0);
    tick();
    in_valid = 1'b0;
    addr     = $urandom;
    rs2_data = $urandom;
    #4;
    chk("vec_b0_valid", mem_valid, 1'b1);
    chk("vec_b0_addr", mem_addr, v.a0);
    chk("vec_b0_we", mem_we, v.we0);
    chk("vec_b0_wdata", mem_wdata, v.d0);
    chk("vec_b0_err", misalign_err, ee);
    tick();
    if (nb == 2) begin
      #4;
      chk("vec_b1_valid", mem_valid, 1'b1);
      chk("vec_b1_addr", mem_addr, v.a1);
      chk("vec_b1_we", mem_we, v.we1);
      chk("vec_b1_wdata", mem_wdata, v.d1);
      chk("vec_b1_err", misalign_err, 1'b0);
      tick();
    end
    #4;
    chk("vec_end_valid", mem_valid, 1'b0);
    chk("vec_end_we", mem_we, 4'b0);
    chk("vec_end_err", misalign_err, 1'b0);
    tick();
  endtask

  initial begin
    tbl[0] = '{3'b000, 32'h1002, 32'h000000AB,
               32'h1000, 4'b0100, 32'hABAB0000, 32'h0, 4'b0000, 32'h0};
    tbl[1] = '{3'b010, 32'h2003, 32'h11223344,
               32'h2000, 4'b1000, 32'h44000000,
               32'h2004, 4'b0111, 32'h00112233};
    tbl[2] = '{3'b001, 32'h0100, 32'hCAFEBEEF,
               32'h0100, 4'b0011, 32'hBEEFBEEF, 32'h0, 4'b0000, 32'h0};
    tbl[3] = '{3'b001, 32'h0103, 32'h00001234,
               32'h0100, 4'b1000, 32'h34000000,
               32'h0104, 4'b0001, 32'h00123412};
    tbl[4] = '{3'b010, 32'hFFFFFFFE, 32'hDEADBEEF,
               32'hFFFFFFFC, 4'b1100, 32'hBEEF0000,
               32'h00000000, 4'b0011, 32'h0000DEAD};
    tbl[5] = '{3'b000, 32'h0007, 32'h0000005A,
               32'h0004, 4'b1000, 32'h5A000000, 32'h0, 4'b0000, 32'h0};
    tbl[6] = '{3'b010, 32'h0040, 32'h01020304,
               32'h0040, 4'b1111, 32'h01020304, 32'h0, 4'b0000, 32'h0};

    rst = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
    instruction = '0; addr = '0; rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_we", mem_we, 4'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_err", misalign_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    tick();

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // held request under backpressure with a second store queued
    in_valid = 1'b1; instruction = mk(OPC_ST, 3'b001);
    addr = 32'h100; rs2_data = 32'hCAFEBEEF; mem_ready = 1'b0;
    tick();
    instruction = mk(OPC_ST, 3'b010);
    addr = 32'h200; rs2_data = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("bp_valid", mem_valid, 1'b1);
      chk("bp_addr", mem_addr, 32'h100);
      chk("bp_we", mem_we, 4'b0011);
      chk("bp_wdata", mem_wdata, 32'hBEEFBEEF);
      chk("bp_stall", stall, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    #4;
    chk("bp_hs_ready", in_ready, 1'b1);
    chk("bp_hs_stall", stall, 1'b0);
    tick();
    in_valid = 1'b0;
    #4;
    chk("bp2_valid", mem_valid, 1'b1);
    chk("bp2_addr", mem_addr, 32'h200);
    chk("bp2_we", mem_we, 4'b1111);
    chk("bp2_wdata", mem_wdata, 32'h11111111);
    tick();
    #4;
    chk("bp_end_valid", mem_valid, 1'b0);
    tick();

    // back-to-back stores with no bubble
    in_valid = 1'b1; instruction = mk(OPC_ST, 3'b010);
    addr = 32'h0; rs2_data = 32'hA0A0A0A0; mem_ready = 1'b1;
    tick();
    addr = 32'h4; rs2_data = 32'hB1B1B1B1;
    #4;
    chk("b2b_valid0", mem_valid, 1'b1);
    chk("b2b_addr0", mem_addr, 32'h0);
    chk("b2b_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    #4;
    chk("b2b_valid1", mem_valid, 1'b1);
    chk("b2b_addr1", mem_addr, 32'h4);
    chk("b2b_wdata1", mem_wdata, 32'hB1B1B1B1);
    tick();
    #4;
    chk("b2b_end", mem_valid, 1'b0);
    tick();

    // reset abandons a stalled beat0 and its pending beat1
    in_valid = 1'b1; instruction = mk(OPC_ST, 3'b010);
    addr = 32'hFFFFFFFE; rs2_data = 32'hDEADBEEF; mem_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #4;
    chk("rmid_valid", mem_valid, 1'b1);
    chk("rmid_addr", mem_addr, 32'hFFFFFFFC);
    chk("rmid_we", mem_we, 4'b1100);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    #4;
    chk("rmid_post_valid", mem_valid, 1'b0);
    chk("rmid_post_ready", in_ready, 1'b1);
    chk("rmid_post_we", mem_we, 4'b0);
    tick();
    #4;
    chk("rmid_no_b1", mem_valid, 1'b0);
    tick();

    // ignored instructions
    in_valid = 1'b1; instruction = mk(OPC_ST, 3'b011); addr = 32'h300;
    #4;
    chk("ign_f3_stall", stall, 1'b0);
    tick();
    instruction = mk(5'b01100, 3'b010);
    #4;
    chk("ign_f3_valid", mem_valid, 1'b0);
    chk("ign_op_stall", stall, 1'b0);
    tick();
    in_valid = 1'b0;
    #4;
    chk("ign_op_valid", mem_valid, 1'b0);
    tick();

    // randomized run against the reference model
    eerr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      opc = ($urandom_range(0, 3) != 0) ? OPC_ST : 5'($urandom);
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom)
                                       : 3'($urandom_range(0, 2));
      tmp = $urandom;
      tmp[6:2] = opc;
      tmp[14:12] = f3;
      instruction = tmp;
      addr = $urandom;
      if ($urandom_range(0, 15) == 0)
        addr = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      rs2_data = $urandom;
      mem_ready = ($urandom_range(0, 2) != 0);
      #4;
      st = (opc == OPC_ST) && (f3 <= 3'd2);
      exp_ir = (q.size() == 0) || (q.size() == 1 && mem_ready);
      chk("rnd_in_ready", in_ready, exp_ir);
      chk("rnd_stall", stall, in_valid && st && !exp_ir);
      chk("rnd_valid", mem_valid, q.size() != 0);
      chk("rnd_err", misalign_err, eerr);
      if (q.size() == 0) begin
        chk("rnd_idle_we", mem_we, 4'b0);
      end else begin
        chk("rnd_addr", mem_addr, q[0].a);
        chk("rnd_we", mem_we, q[0].we);
        chk("rnd_wdata", mem_wdata, q[0].d);
        if (mem_ready) void'(q.pop_front());
      end
      eerr = 1'b0;
      if (in_valid && st && exp_ir) begin
        ref_lanes(f3, addr[1:0], rs2_data, rm, rd);
        b.a  = {addr[31:2], 2'b00};
        b.we = rm[3:0];
        b.d  = rd[31:0];
        q.push_back(b);
        if (rm[7:4] != 4'b0) begin
          if (SPLIT) begin
            b.a  = {addr[31:2], 2'b00} + 32'd4;
            b.we = rm[7:4];
            b.d  = rd[63:32];
            q.push_back(b);
          end else begin
            eerr = 1'b1;
          end
        end
      end
      tick();
    end

    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
